operand_fetch: RTL

Operand fetch stage that sits directly upstream of the multiplier datapath. On `start` it reads `PAIRS` consecutive pairs of 16-bit words from an external synchronous-read operand memory. Each pair is presented to the datapath controller as `op_a`/`op_b` under a valid/ready handshake. The controller's `op_ready` gates the datapath's load of its input shift registers. `done` signals that the whole operand set has been consumed.

---
 rtl/operand_fetch.sv | 84 ++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage. It reads PAIRS consecutive word pairs from a
// synchronous-read operand memory and hands each pair to the multiplier
// datapath controller through a valid/ready handshake.
module operand_fetch #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int PAIRS  = 8
) (
  input  logic              clk,
  input  logic              rst,       // active-low, asynchronous
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              busy,
  output logic              done
);

  // The pair counter never goes below one bit, even for a single pair.
  localparam int KW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, VALID, DONE} state_e;

  state_e            state_q;
  logic [KW-1:0]     k_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;

  // Word index of the current read: 2k for op_a, 2k+1 for op_b.
  logic [KW:0] word_idx;

  // Sequencer: read A, read B, capture the trailing read, present, repeat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          k_q     <= '0;
          state_q <= RD_A;
        end
        RD_A:  state_q <= RD_B;
        // Data for the RD_A address arrives this cycle.
        RD_B: begin
          op_a_q  <= mem_data;
          state_q <= CAP_B;
        end
        // Data for the RD_B address arrives this cycle.
        CAP_B: begin
          op_b_q  <= mem_data;
          state_q <= VALID;
        end
        VALID: if (op_ready) begin
          if (k_q == K_LAST) begin
            state_q <= DONE;
          end else begin
            k_q     <= k_q + KW'(1);
            state_q <= RD_A;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state registers only; no input reaches an output.
  assign word_idx = {k_q, (state_q == RD_B)};
  assign mem_rd   = (state_q == RD_A) || (state_q == RD_B);
  assign mem_addr = mem_rd ? ADDR_W'(word_idx) : '0;
  assign op_valid = (state_q == VALID);
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;

endmodule
